// File: rtl/ahb_arb_rr.sv
// Per-slave AHB address-phase arbiter: priority first, round-robin among equal
// priority, grant held across slave stalls and locked while HMASTLOCK is set.
module ahb_arb_rr #(
   parameter int unsigned MASTERS     = 8,
   parameter int unsigned MASTERS_BIT = $clog2(MASTERS)
) (
   input  logic                           HCLK,
   input  logic                           HRESET,
   input  logic [MASTERS*MASTERS_BIT-1:0] ARB_PRIORITY,
   input  logic [MASTERS-1:0]             ARB_REQ,
   output logic [MASTERS-1:0]             ARB_REQ_ACK,
   output logic [MASTERS-1:0]             ARB_GRANT,
   input  logic [MASTERS-1:0]             ARB_GRANT_ACK,
   input  logic                           ARB_PRIORITY_LOCK,
   output logic [MASTERS_BIT-1:0]         ARB_WINNER,
   output logic                           ARB_BUSY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      LOCK = 2'd2
   } state_t;

   state_t                 state, state_nxt;
   logic [MASTERS-1:0]     hold_oh, hold_nxt;
   logic [MASTERS_BIT-1:0] last_ptr, ptr_nxt;

   logic [MASTERS_BIT-1:0] maxp;
   logic [MASTERS-1:0]     cand;
   logic [MASTERS-1:0]     fresh_oh;
   logic [MASTERS_BIT-1:0] hi_idx, lo_idx, fresh_idx;
   logic                   hi_found, lo_found;
   logic                   held_req;
   logic                   ack_hit;

   // Highest requested priority and the set of requesters that carry it
   always_comb begin
      maxp = '0;
      cand = '0;
      for (int unsigned m = 0; m < MASTERS; m++) begin
         if (ARB_REQ[m] && (ARB_PRIORITY[m*MASTERS_BIT +: MASTERS_BIT] > maxp))
            maxp = ARB_PRIORITY[m*MASTERS_BIT +: MASTERS_BIT];
      end
      for (int unsigned m = 0; m < MASTERS; m++) begin
         cand[m] = ARB_REQ[m] && (ARB_PRIORITY[m*MASTERS_BIT +: MASTERS_BIT] == maxp);
      end
   end

   // Round-robin pick: first candidate above last_ptr, else wrap to the lowest one
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int unsigned m = 0; m < MASTERS; m++) begin
         if (cand[m] && (m > 32'(last_ptr)) && !hi_found) begin
            hi_found = 1'b1;
            hi_idx   = MASTERS_BIT'(m);
         end
         if (cand[m] && !lo_found) begin
            lo_found = 1'b1;
            lo_idx   = MASTERS_BIT'(m);
         end
      end
      fresh_idx = hi_found ? hi_idx : lo_idx;
      fresh_oh  = '0;
      if (lo_found)
         fresh_oh[fresh_idx] = 1'b1;
   end

   // Grant select by hold state, plus winner encode and acknowledge
   always_comb begin
      held_req = |(hold_oh & ARB_REQ);
      unique case (state)
         HOLD:    ARB_GRANT = held_req ? hold_oh : fresh_oh;
         LOCK:    ARB_GRANT = hold_oh & ARB_REQ;
         default: ARB_GRANT = fresh_oh;
      endcase
      ARB_WINNER = '0;
      for (int unsigned m = 0; m < MASTERS; m++) begin
         if (ARB_GRANT[m])
            ARB_WINNER = MASTERS_BIT'(m);
      end
      ARB_REQ_ACK = ARB_GRANT_ACK & ARB_GRANT;
      ack_hit     = |ARB_REQ_ACK;
      ARB_BUSY    = (state != IDLE);
   end

   // Next hold state, held grant and round-robin pointer
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_oh;
      ptr_nxt   = last_ptr;
      unique case (state)
         IDLE, HOLD: begin
            if (ack_hit) begin
               if (ARB_PRIORITY_LOCK) begin
                  state_nxt = LOCK;
                  hold_nxt  = ARB_GRANT;
               end else begin
                  state_nxt = IDLE;
                  hold_nxt  = '0;
                  ptr_nxt   = ARB_WINNER;
               end
            end else if (state == HOLD && !held_req) begin
               // held master abandoned its request; re-arbitrate from scratch
               state_nxt = IDLE;
               hold_nxt  = '0;
            end else if (state == IDLE && ARB_GRANT != '0) begin
               state_nxt = HOLD;
               hold_nxt  = ARB_GRANT;
            end
         end
         LOCK: begin
            if (ack_hit) begin
               if (!ARB_PRIORITY_LOCK) begin
                  state_nxt = IDLE;
                  hold_nxt  = '0;
                  ptr_nxt   = ARB_WINNER;
               end
            end else if (!held_req && !ARB_PRIORITY_LOCK) begin
               state_nxt = IDLE;
               hold_nxt  = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            hold_nxt  = '0;
         end
      endcase
   end

   // State registers; last_ptr resets to the top index so master 0 goes first
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state    <= IDLE;
         hold_oh  <= '0;
         last_ptr <= MASTERS_BIT'(MASTERS - 1);
      end else begin
         state    <= state_nxt;
         hold_oh  <= hold_nxt;
         last_ptr <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_ahb_arb_rr.sv
// Directed bench for ahb_arb_rr with four masters.
module tb_ahb_arb_rr;

   localparam int unsigned M  = 4;
   localparam int unsigned MB = 2;

   logic          HCLK;
   logic          HRESET;
   logic [M*MB-1:0] ARB_PRIORITY;
   logic [M-1:0]  ARB_REQ;
   logic [M-1:0]  ARB_REQ_ACK;
   logic [M-1:0]  ARB_GRANT;
   logic [M-1:0]  ARB_GRANT_ACK;
   logic          ARB_PRIORITY_LOCK;
   logic [MB-1:0] ARB_WINNER;
   logic          ARB_BUSY;

   int total = 0;
   int bad   = 0;

   ahb_arb_rr #(.MASTERS(M), .MASTERS_BIT(MB)) dut (
      .HCLK              (HCLK),
      .HRESET            (HRESET),
      .ARB_PRIORITY      (ARB_PRIORITY),
      .ARB_REQ           (ARB_REQ),
      .ARB_REQ_ACK       (ARB_REQ_ACK),
      .ARB_GRANT         (ARB_GRANT),
      .ARB_GRANT_ACK     (ARB_GRANT_ACK),
      .ARB_PRIORITY_LOCK (ARB_PRIORITY_LOCK),
      .ARB_WINNER        (ARB_WINNER),
      .ARB_BUSY          (ARB_BUSY)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // advance one clock and settle just past the edge
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   // apply requests/lock; the slave acks the current grant when addr_ack is set
   task automatic drive(input logic [M-1:0] req, input bit addr_ack, input bit lock);
      ARB_REQ           = req;
      ARB_PRIORITY_LOCK = lock;
      ARB_GRANT_ACK     = '0;
      #1;
      ARB_GRANT_ACK = addr_ack ? ARB_GRANT : '0;
      #1;
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      drive(4'b0000, 1'b0, 1'b0);
      tick();
      HRESET = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive(4'b0000, 1'b0, 1'b0);
      total++; if (ARB_GRANT !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", ARB_GRANT); end
      total++; if (ARB_WINNER !== 2'd0) begin bad++; $display("FAIL reset_winner got=%0d exp=0", ARB_WINNER); end
      total++; if (ARB_BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", ARB_BUSY); end
      total++; if (ARB_REQ_ACK !== 4'b0000) begin bad++; $display("FAIL reset_req_ack got=%b exp=0000", ARB_REQ_ACK); end
   endtask

   task automatic test_round_robin();
      logic [M-1:0]  seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [MB-1:0] idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      ARB_PRIORITY = 8'b00_00_00_00;
      for (int i = 0; i < 5; i++) begin
         drive(4'b1111, 1'b1, 1'b0);
         total++; if (ARB_GRANT !== seq[i]) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, ARB_GRANT, seq[i]); end
         total++; if (ARB_WINNER !== idx[i]) begin bad++; $display("FAIL rr_winner[%0d] got=%0d exp=%0d", i, ARB_WINNER, idx[i]); end
         total++; if (ARB_REQ_ACK !== seq[i]) begin bad++; $display("FAIL rr_req_ack[%0d] got=%b exp=%b", i, ARB_REQ_ACK, seq[i]); end
         tick();
      end
   endtask

   task automatic test_priority();
      ARB_PRIORITY = 8'b00_11_00_00;
      for (int i = 0; i < 3; i++) begin
         drive(4'b1111, 1'b1, 1'b0);
         total++; if (ARB_GRANT !== 4'b0100) begin bad++; $display("FAIL prio_grant[%0d] got=%b exp=0100", i, ARB_GRANT); end
         tick();
      end
      drive(4'b1011, 1'b1, 1'b0);
      total++; if (ARB_GRANT !== 4'b1000) begin bad++; $display("FAIL prio_after_drop0 got=%b exp=1000", ARB_GRANT); end
      tick();
      drive(4'b1011, 1'b1, 1'b0);
      total++; if (ARB_GRANT !== 4'b0001) begin bad++; $display("FAIL prio_after_drop1 got=%b exp=0001", ARB_GRANT); end
      tick();
      ARB_PRIORITY = 8'b00_00_00_00;
   endtask

   task automatic test_stall_hold();
      logic [M-1:0] reqs [3] = '{4'b0001, 4'b1001, 4'b1001};
      logic         busy [3] = '{1'b0, 1'b1, 1'b1};
      ARB_PRIORITY = 8'b11_00_00_00;
      for (int i = 0; i < 3; i++) begin
         drive(reqs[i], 1'b0, 1'b0);
         total++; if (ARB_GRANT !== 4'b0001) begin bad++; $display("FAIL stall_grant[%0d] got=%b exp=0001", i, ARB_GRANT); end
         total++; if (ARB_BUSY !== busy[i]) begin bad++; $display("FAIL stall_busy[%0d] got=%b exp=%b", i, ARB_BUSY, busy[i]); end
         tick();
      end
      drive(4'b1001, 1'b1, 1'b0);
      total++; if (ARB_REQ_ACK !== 4'b0001) begin bad++; $display("FAIL stall_ack got=%b exp=0001", ARB_REQ_ACK); end
      total++; if (ARB_BUSY !== 1'b1) begin bad++; $display("FAIL stall_busy_ack got=%b exp=1", ARB_BUSY); end
      tick();
      drive(4'b1001, 1'b1, 1'b0);
      total++; if (ARB_GRANT !== 4'b1000) begin bad++; $display("FAIL stall_next_grant got=%b exp=1000", ARB_GRANT); end
      total++; if (ARB_BUSY !== 1'b0) begin bad++; $display("FAIL stall_idle_busy got=%b exp=0", ARB_BUSY); end
      tick();
      ARB_PRIORITY = 8'b00_00_00_00;
   endtask

   task automatic test_mastlock();
      drive(4'b0010, 1'b1, 1'b1);
      total++; if (ARB_GRANT !== 4'b0010) begin bad++; $display("FAIL lock_first got=%b exp=0010", ARB_GRANT); end
      tick();
      drive(4'b0011, 1'b1, 1'b1);
      total++; if (ARB_GRANT !== 4'b0010) begin bad++; $display("FAIL lock_next got=%b exp=0010", ARB_GRANT); end
      total++; if (ARB_BUSY !== 1'b1) begin bad++; $display("FAIL lock_busy got=%b exp=1", ARB_BUSY); end
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(4'b0001, 1'b0, 1'b1);
         total++; if (ARB_GRANT !== 4'b0000) begin bad++; $display("FAIL lock_masked[%0d] got=%b exp=0000", i, ARB_GRANT); end
         total++; if (ARB_REQ_ACK !== 4'b0000) begin bad++; $display("FAIL lock_masked_ack[%0d] got=%b exp=0000", i, ARB_REQ_ACK); end
         tick();
      end
      drive(4'b0011, 1'b1, 1'b0);
      total++; if (ARB_REQ_ACK !== 4'b0010) begin bad++; $display("FAIL lock_release_ack got=%b exp=0010", ARB_REQ_ACK); end
      tick();
      drive(4'b0001, 1'b1, 1'b0);
      total++; if (ARB_BUSY !== 1'b0) begin bad++; $display("FAIL lock_idle_busy got=%b exp=0", ARB_BUSY); end
      total++; if (ARB_GRANT !== 4'b0001) begin bad++; $display("FAIL lock_m0_grant got=%b exp=0001", ARB_GRANT); end
      total++; if (ARB_WINNER !== 2'd0) begin bad++; $display("FAIL lock_m0_winner got=%0d exp=0", ARB_WINNER); end
      tick();
   endtask

   task automatic test_abandon();
      do_reset();
      drive(4'b0100, 1'b0, 1'b0);
      total++; if (ARB_GRANT !== 4'b0100) begin bad++; $display("FAIL abandon_hold got=%b exp=0100", ARB_GRANT); end
      tick();
      drive(4'b0011, 1'b0, 1'b0);
      total++; if (ARB_GRANT !== 4'b0001) begin bad++; $display("FAIL abandon_fresh got=%b exp=0001", ARB_GRANT); end
      total++; if (ARB_BUSY !== 1'b1) begin bad++; $display("FAIL abandon_busy got=%b exp=1", ARB_BUSY); end
      tick();
      drive(4'b0011, 1'b0, 1'b0);
      total++; if (ARB_BUSY !== 1'b0) begin bad++; $display("FAIL abandon_idle got=%b exp=0", ARB_BUSY); end
      total++; if (ARB_GRANT !== 4'b0001) begin bad++; $display("FAIL abandon_ptr got=%b exp=0001", ARB_GRANT); end
      tick();
   endtask

   task automatic test_reset_mid_lock();
      drive(4'b1000, 1'b1, 1'b1);
      total++; if (ARB_GRANT !== 4'b1000) begin bad++; $display("FAIL rlock_grant got=%b exp=1000", ARB_GRANT); end
      tick();
      drive(4'b1111, 1'b0, 1'b1);
      total++; if (ARB_GRANT !== 4'b1000) begin bad++; $display("FAIL rlock_locked got=%b exp=1000", ARB_GRANT); end
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      drive(4'b1111, 1'b0, 1'b0);
      total++; if (ARB_BUSY !== 1'b0) begin bad++; $display("FAIL rlock_busy got=%b exp=0", ARB_BUSY); end
      total++; if (ARB_GRANT !== 4'b0001) begin bad++; $display("FAIL rlock_grant_after got=%b exp=0001", ARB_GRANT); end
      tick();
   endtask

   initial begin
      HRESET            = 1'b1;
      ARB_PRIORITY      = '0;
      ARB_REQ           = '0;
      ARB_GRANT_ACK     = '0;
      ARB_PRIORITY_LOCK = 1'b0;
      test_reset();
      test_round_robin();
      test_priority();
      test_stall_hold();
      test_mastlock();
      test_abandon();
      test_reset_mid_lock();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
